// File: rtl/osc_sample_gen.sv
`default_nettype none
// ============================================================================
// osc_sample_gen : sample-rate timer, 24-bit phase accumulator, waveform shaper
//                  and gain stage producing Q5.16 samples for the SVF.
//                  Optional noise source enabled by OSC_SAMPLE_GEN_NOISE_EN.
// Revision       : 1.0
// ============================================================================
module osc_sample_gen #(
  parameter int SAMPLE_DIV = 2834
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] fcw,
  input  logic [1:0]  wave_sel,
  input  logic [15:0] gain,
  input  logic        phase_rst,
  input  logic        done,
  input  logic        ovr_clr,
  output logic [20:0] x,
  output logic        x_valid,
  output logic        busy,
  output logic        overrun
);
  localparam int               CNT_W   = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic               accept;
  logic [23:0]        phase;
  logic [23:0]        ph_lat;
  logic [1:0]         ws_lat;
  logic [15:0]        gain_lat;
  logic [15:0]        tri_t;
  logic signed [16:0] w;
  logic signed [16:0] noise_w;
  logic signed [33:0] prod;
  logic               unused_bits;

  assign tick    = (cnt == CNT_MAX);
  // A tick is taken in IDLE, or in WAIT when the SVF finishes in the same cycle.
  assign accept  = tick && en && ((state == IDLE) || ((state == WAIT) && done));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (phase_rst)
        phase <= '0;
      else if (tick)
        phase <= phase + fcw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (accept)
          state_nxt = CALC;
        else if (done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_lat   <= '0;
      ws_lat   <= '0;
      gain_lat <= '0;
      x        <= '0;
      x_valid  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      x_valid <= (state == CALC);
      if (accept) begin
        ph_lat   <= phase;
        ws_lat   <= wave_sel;
        gain_lat <= gain;
      end
      if (state == CALC)
        x <= {{4{prod[32]}}, prod[32:16]};
      if (tick && en && !accept)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

  assign tri_t = ph_lat[23] ? ~ph_lat[22:7] : ph_lat[22:7];

  always_comb begin
    w = '0;
    case (ws_lat)
      2'b00:   w = {ph_lat[23:8], 1'b0};
      2'b01:   w = ph_lat[23] ? 17'h10000 : 17'h0FFFF;
      2'b10:   w = {tri_t, 1'b0} - 17'h10000;
      default: w = noise_w;
    endcase
  end

  // |w| <= 2^16 and gain < 2^16, so the product never overflows 34 bits.
  assign prod        = 34'(w) * 34'($signed({1'b0, gain_lat}));
  assign unused_bits = ^{prod[33], prod[15:0], ph_lat[6:0]};

`ifdef OSC_SAMPLE_GEN_NOISE_EN
  logic [16:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lfsr <= 17'h1;
    else if (tick)
      lfsr <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
  end

  assign noise_w = lfsr;
`else
  assign noise_w = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_osc_sample_gen.sv
`default_nettype none
// tb_osc_sample_gen: vector table, directed corner sequences and randomized
// traffic checked cycle by cycle against a behavioural model.
module tb_osc_sample_gen;
  localparam int DIV = 8;
`ifdef OSC_SAMPLE_GEN_NOISE_EN
  localparam bit NOISE_ON = 1'b1;
`else
  localparam bit NOISE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        phase_rst = 1'b0;
  logic        done = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [23:0] fcw = '0;
  logic [1:0]  wave_sel = '0;
  logic [15:0] gain = '0;
  logic [20:0] x;
  logic        x_valid;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  osc_sample_gen #(.SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .fcw(fcw), .wave_sel(wave_sel), .gain(gain),
    .phase_rst(phase_rst), .done(done), .ovr_clr(ovr_clr),
    .x(x), .x_valid(x_valid), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference sample from the waveform rules, in plain integer arithmetic.
  function automatic logic [20:0] ref_x(int unsigned ph, logic [1:0] ws, int unsigned g,
                                        int unsigned lf);
    longint w, t, p;
    case (ws)
      2'd0: begin
        w = longint'((ph >> 8) & 32'hFFFF) * 2;
        if (w >= 65536) w = w - 131072;
      end
      2'd1: w = (ph >= 32'h800000) ? -65536 : 65535;
      2'd2: begin
        t = longint'((ph >> 7) & 32'hFFFF);
        if (ph >= 32'h800000) t = 65535 - t;
        w = 2 * t - 65536;
      end
      default: begin
        if (!NOISE_ON) w = 0;
        else if (lf >= 65536) w = longint'(lf) - 131072;
        else w = longint'(lf);
      end
    endcase
    p = (w * longint'(g)) >>> 16;
    return p[20:0];
  endfunction

  function automatic int unsigned lfsr_step(int unsigned l);
    return ((l << 1) | (((l >> 16) ^ (l >> 13)) & 1)) & 32'h1FFFF;
  endfunction

  // Model: a sample accepted in cycle a is strobed in a+2; done counts from a+3.
  int unsigned m_cnt, m_phase, m_lfsr, m_cyc, m_acc;
  bit          m_busy, m_ovr, m_tick, m_ovr_new;
  logic [20:0] m_x, m_px;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_phase = 0; m_lfsr = 1; m_cyc = 0; m_acc = 0;
      m_busy = 0; m_ovr = 0; m_x = '0; m_px = '0;
    end else begin
      m_tick    = (m_cnt == DIV - 1);
      m_ovr_new = 0;
      if (m_tick) m_lfsr = lfsr_step(m_lfsr);
      if (m_busy && (m_cyc >= m_acc + 3) && done) m_busy = 0;
      if (m_tick && en) begin
        if (!m_busy) begin
          m_busy = 1;
          m_acc  = m_cyc;
          m_px   = ref_x(m_phase, wave_sel, gain, m_lfsr);
        end else begin
          m_ovr_new = 1;
        end
      end
      if (m_ovr_new) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
      if (phase_rst) m_phase = 0;
      else if (m_tick) m_phase = (m_phase + fcw) & 32'hFFFFFF;
      m_cnt = (m_cnt + 1) % DIV;
      m_cyc++;
      if (m_busy && (m_cyc == m_acc + 2)) m_x = m_px;
    end
  end

  int unsigned xv_count = 0;
  logic [20:0] xq[$];

  always @(negedge clk) begin
    #1;
    if (rst) begin
      chk("x_valid", x_valid, m_busy && (m_cyc == m_acc + 2));
      chk("busy", busy, m_busy);
      chk("overrun", overrun, m_ovr);
      chk("x", x, m_x);
      if (x_valid) begin
        xv_count++;
        xq.push_back(x);
      end
    end
  end

  // Stand-in for the SVF: done two cycles after each x_valid.
  bit auto_done = 1;
  int dly = 0;

  task automatic step();
    @(negedge clk);
    if (auto_done) begin
      done = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) done = 1'b1;
      end
      if (x_valid) dly = 2;
    end
  endtask

  task automatic wait_cnt(input int k);
    int n = 0;
    do begin
      step();
      n++;
    end while ((m_cnt != k) && (n < 3 * DIV));
  endtask

  typedef struct {
    logic [1:0]       ws;
    logic [23:0]      fcw;
    logic [15:0]      gain;
    logic [3:0][20:0] e;
  } row_t;

  function automatic row_t mk(logic [1:0] ws, logic [23:0] f, logic [15:0] g,
                              logic [20:0] a, logic [20:0] b, logic [20:0] c, logic [20:0] d);
    row_t r;
    r.ws = ws; r.fcw = f; r.gain = g;
    r.e[0] = a; r.e[1] = b; r.e[2] = c; r.e[3] = d;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    row_t        rows[$];
    int          base, n;
    int unsigned base_v, t_tick;

    rows.push_back(mk(2'd0, 24'h400000, 16'hFFFF, 21'h0, 21'h07FFF, 21'h1F0001, 21'h1F8000));
    rows.push_back(mk(2'd1, 24'h400000, 16'h8000, 21'h07FFF, 21'h07FFF, 21'h1F8000, 21'h1F8000));
    rows.push_back(mk(2'd2, 24'h400000, 16'hFFFF, 21'h1F0001, 21'h0, 21'h0FFFD, 21'h1FFFFE));
    rows.push_back(mk(2'd1, 24'h100000, 16'h8000, 21'h07FFF, 21'h07FFF, 21'h07FFF, 21'h07FFF));
    rows.push_back(mk(2'd0, 24'h100000, 16'h8000, 21'h0, 21'h01000, 21'h02000, 21'h03000));
    if (!NOISE_ON)
      rows.push_back(mk(2'd3, 24'h123456, 16'hFFFF, 21'h0, 21'h0, 21'h0, 21'h0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", x, 21'h0);
    chk("reset_x_valid", x_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;

    // Waveform table: phase cleared, then four consecutive samples.
    for (int r = 0; r < rows.size(); r++) begin
      wait_cnt(2);
      wave_sel  = rows[r].ws;
      fcw       = rows[r].fcw;
      gain      = rows[r].gain;
      phase_rst = 1'b1;
      step();
      phase_rst = 1'b0;
      base = xq.size();
      n = 0;
      while ((xq.size() < base + 4) && (n < 10 * DIV)) begin
        step();
        n++;
      end
      chk($sformatf("row%0d_samples", r), xq.size() >= base + 4, 1'b1);
      for (int i = 0; i < 4; i++)
        if (base + i < xq.size())
          chk($sformatf("row%0d_x%0d", r, i), xq[base + i], rows[r].e[i]);
    end

    // Overrun with done held low, then clear and recover.
    en = 1'b0;
    repeat (3 * DIV) step();
    auto_done = 0; dly = 0; done = 1'b0;
    wave_sel = 2'd0; fcw = 24'h010000; gain = 16'h4000;
    wait_cnt(2);
    en = 1'b1;
    base_v = xv_count;
    repeat (2 * DIV) step();
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_one_issue", xv_count - base_v, 1);
    en = 1'b0;
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    step();
    chk("ovr_clr", overrun, 1'b0);
    chk("ovr_still_busy", busy, 1'b1);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk("idle_after_done", busy, 1'b0);
    en = 1'b1;
    n = 0;
    while ((x_valid !== 1'b1) && (n < 3 * DIV)) begin step(); n++; end
    chk("reissue", x_valid, 1'b1);
    chk("ovr_stays_clear", overrun, 1'b0);

    // done and tick in the same WAIT cycle.
    step();
    wait_cnt(DIV - 1);
    done = 1'b1;
    t_tick = m_cyc;
    step();
    done = 1'b0;
    n = 0;
    while ((x_valid !== 1'b1) && (n < 10)) begin step(); n++; end
    chk("wait_tick_latency", m_cyc - t_tick, 2);
    chk("wait_tick_no_ovr", overrun, 1'b0);
    dly = 2;
    auto_done = 1;

    // en low: no samples while the phase keeps advancing.
    wait_cnt(2);
    en = 1'b0; wave_sel = 2'd0; fcw = 24'h100000; gain = 16'h8000; phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
    base_v = xv_count;
    repeat (3 * DIV) step();
    chk("en0_no_issue", xv_count - base_v, 0);
    chk("en0_idle", busy, 1'b0);
    en = 1'b1;
    n = 0;
    while ((x_valid !== 1'b1) && (n < 3 * DIV)) begin step(); n++; end
    chk("en0_phase_kept", x, 21'h03000);

    // Reset asserted in WAIT with overrun set.
    en = 1'b0; wave_sel = 2'd1; gain = 16'h8000; fcw = 24'h0; phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
    repeat (2 * DIV) step();
    auto_done = 0; dly = 0; done = 1'b0; en = 1'b1;
    n = 0;
    while ((x_valid !== 1'b1) && (n < 3 * DIV)) begin step(); n++; end
    repeat (DIV) step();
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_ovr", overrun, 1'b1);
    chk("pre_rst_x", x, 21'h07FFF);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_x", x, 21'h0);
    chk("rst_x_valid", x_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    auto_done = 1;
    n = 0;
    while ((x_valid !== 1'b1) && (n < 3 * DIV)) begin step(); n++; end
    chk("restart_latency", n, DIV + 1);

    // Randomized traffic; the per-cycle model comparison does the checking.
    auto_done = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      en        = ($urandom % 8) != 0;
      phase_rst = ($urandom % 40) == 0;
      ovr_clr   = ($urandom % 12) == 0;
      done      = ($urandom % 4) == 0;
      if (($urandom % 16) == 0) begin
        wave_sel = 2'($urandom);
        fcw      = 24'($urandom);
        gain     = 16'($urandom);
      end
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
